fetch_buffer_stage: RTL and testbench

FETCH_BUFFER_STAGE -- requirements
Module: fetch_buffer_stage

---
 rtl/core_pkg.sv | 11 +
 rtl/fetch_buffer_stage_pkg.sv | 17 +
 rtl/fetch_buffer_stage_if.sv | 12 +
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/fetch_buffer_stage.sv | 84 ++++++++
 tb/tb_fetch_buffer_stage.sv | 213 +++++++++++++++++++++
 6 files changed

// File: rtl/core_pkg.sv
// Core-wide widths and the decode-facing instruction type shared by the front end.
package core_pkg;
  localparam int ARCH_LEN = 32;
  localparam int PHY_LEN  = 32;
  localparam int INST_LEN = 32;

  typedef struct packed {
    logic                valid;
    logic [INST_LEN-1:0] inst;
  } inst_fetched_t;
endpackage

// File: rtl/fetch_buffer_stage_pkg.sv
// Types local to the fetch stage: queue entry, fetch FSM states and the default queue depth.
package fetch_buffer_stage_pkg;
  import core_pkg::*;

  localparam int FQ_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [INST_LEN-1:0] inst;
    logic [ARCH_LEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    MISS
  } fetch_state_e;
endpackage

// File: rtl/fetch_buffer_stage_if.sv
// Fetch-to-icache bus: the fetch stage is the master, the icache answers as the slave.
interface fetch_buffer_stage_if;
  import core_pkg::*;

  logic [PHY_LEN-1:0]  ic_addr;
  logic                ic_req;
  logic [INST_LEN-1:0] ic_data;
  logic                ic_miss;

  modport master (output ic_addr, ic_req, input ic_data, ic_miss);
  modport slave  (input ic_addr, ic_req, output ic_data, ic_miss);
endinterface

// File: rtl/fetch_fifo.sv
// Small circular queue with push/pop/flush; head is presented combinationally.
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0]
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  T                         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output T                         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  T              mem_q [DEPTH];
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers alone decide which slots are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/fetch_buffer_stage.sv
// Fetch stage: PC/FSM driving the icache and a fetch queue feeding decode; br_tk redirects and flushes.
module fetch_buffer_stage
  import core_pkg::*;
  import fetch_buffer_stage_pkg::*;
#(
  parameter int                  FQ_DEPTH = FQ_DEPTH_DEFAULT,
  parameter logic [ARCH_LEN-1:0] BOOT_PC  = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  fetch_buffer_stage_if.master      ic,
  input  logic                      stall_in,
  input  logic                      br_tk,
  input  logic [ARCH_LEN-1:0]       pc_br_tk,
  output inst_fetched_t             inst_out,
  output logic [ARCH_LEN-1:0]       pc_out,
  output logic [ARCH_LEN-1:0]       npc_out,
  output logic [$clog2(FQ_DEPTH):0] fq_count
);
  fetch_state_e        state_q, state_d;
  logic [ARCH_LEN-1:0] pc_q, pc_d;
  fetch_entry_t        fq_head, fq_new;
  logic                fq_full, fq_empty;
  logic                fetch_req, enq, head_valid, deq;

  // A full queue never fetches, even when decode drains it this cycle.
  assign fetch_req  = !rst && (state_q != BOOT) && !fq_full && !br_tk;
  assign enq        = fetch_req && !ic.ic_miss;
  assign head_valid = !rst && !fq_empty && !br_tk;
  assign deq        = head_valid && !stall_in;

  assign fq_new.inst = ic.ic_data;
  assign fq_new.pc   = pc_q;

  fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (enq),
    .data_i  (fq_new),
    .pop_i   (deq),
    .flush_i (br_tk),
    .head_o  (fq_head),
    .full_o  (fq_full),
    .empty_o (fq_empty),
    .count_o (fq_count)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (br_tk) begin
      state_d = RUN;
      pc_d    = pc_br_tk & ~ARCH_LEN'(3);
    end else begin
      if (enq) pc_d = pc_q + ARCH_LEN'(4);
      unique case (state_q)
        BOOT:    state_d = RUN;
        RUN:     if (fetch_req && ic.ic_miss) state_d = MISS;
        MISS:    if (!ic.ic_miss) state_d = RUN;
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= BOOT_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign ic.ic_addr    = pc_q[PHY_LEN-1:0];
  assign ic.ic_req     = fetch_req;
  assign inst_out.valid = head_valid;
  assign inst_out.inst  = rst ? '0 : fq_head.inst;
  assign pc_out        = fq_head.pc;
  assign npc_out       = fq_head.pc + ARCH_LEN'(4);
endmodule

// File: tb/tb_fetch_buffer_stage.sv
// Directed bench for fetch_buffer_stage: the icache model returns addr ^ 0xDEAD0000 as the instruction.
module tb_fetch_buffer_stage;
  import core_pkg::*;
  import fetch_buffer_stage_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                stall_in;
  logic                br_tk;
  logic [ARCH_LEN-1:0] pc_br_tk;
  inst_fetched_t       inst_out;
  logic [ARCH_LEN-1:0] pc_out;
  logic [ARCH_LEN-1:0] npc_out;
  logic [2:0]          fq_count;
  int                  total = 0;
  int                  bad   = 0;

  always #5 clk = ~clk;

  fetch_buffer_stage_if ic_if ();
  assign ic_if.ic_data = ic_if.ic_addr ^ 32'hDEAD_0000;

  fetch_buffer_stage #(
    .FQ_DEPTH (4),
    .BOOT_PC  (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ic       (ic_if),
    .stall_in (stall_in),
    .br_tk    (br_tk),
    .pc_br_tk (pc_br_tk),
    .inst_out (inst_out),
    .pc_out   (pc_out),
    .npc_out  (npc_out),
    .fq_count (fq_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Leaves the bench one cycle after the reset edge, rst low, DUT in BOOT.
  task automatic do_reset();
    rst          = 1'b1;
    stall_in     = 1'b0;
    br_tk        = 1'b0;
    pc_br_tk     = '0;
    ic_if.ic_miss = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    logic [31:0] exp_inst;
    exp_inst = pc ^ 32'hDEAD_0000;
    check({tag, ".valid"}, 64'(inst_out.valid), 64'd1);
    check({tag, ".pc"},    64'(pc_out),         64'(pc));
    check({tag, ".npc"},   64'(npc_out),        64'(pc + 32'd4));
    check({tag, ".inst"},  64'(inst_out.inst),  64'(exp_inst));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    stall_in      = 1'b0;
    br_tk         = 1'b0;
    pc_br_tk      = '0;
    ic_if.ic_miss = 1'b0;
    tick();
    tick();
    check("rst.count", 64'(fq_count), 64'd0);
    check("rst.req",   64'(ic_if.ic_req), 64'd0);
    check("rst.valid", 64'(inst_out.valid), 64'd0);
    check("rst.inst",  64'(inst_out.inst), 64'd0);

    // Straight-line hits, decode never stalls.
    do_reset();
    settle();
    check("hit.boot_req",   64'(ic_if.ic_req), 64'd0);
    check("hit.boot_state", 64'(dut.state_q), 64'(BOOT));
    tick();
    check("hit.c1_req",  64'(ic_if.ic_req), 64'd1);
    check("hit.c1_addr", 64'(ic_if.ic_addr), 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_head("hit.head", 32'(i * 4));
      check("hit.count", 64'(fq_count), 64'd1);
    end

    // Decode stalls until the queue fills, then drains in order across the pointer wrap.
    do_reset();
    stall_in = 1'b1;
    for (int c = 1; c <= 7; c++) tick();
    check("full.count", 64'(fq_count), 64'd4);
    check("full.req",   64'(ic_if.ic_req), 64'd0);
    check("full.addr",  64'(ic_if.ic_addr), 64'h10);
    tick();
    stall_in = 1'b0;
    settle();
    for (int i = 0; i < 5; i++) begin
      check_head("drain.head", 32'(i * 4));
      if (i == 0) check("drain.req_full", 64'(ic_if.ic_req), 64'd0);
      if (i == 1) check("drain.count", 64'(fq_count), 64'd3);
      tick();
    end

    // Five-cycle miss at PC 0x8.
    do_reset();
    tick();
    tick();
    tick();
    ic_if.ic_miss = 1'b1;
    settle();
    check("miss.c3_addr", 64'(ic_if.ic_addr), 64'h8);
    for (int c = 4; c <= 7; c++) begin
      tick();
      check("miss.state", 64'(dut.state_q), 64'(MISS));
      check("miss.addr",  64'(ic_if.ic_addr), 64'h8);
      check("miss.count", 64'(fq_count), 64'd0);
    end
    tick();
    ic_if.ic_miss = 1'b0;
    settle();
    check("miss.exit_state", 64'(dut.state_q), 64'(MISS));
    check("miss.exit_req",   64'(ic_if.ic_req), 64'd1);
    tick();
    check_head("miss.first", 32'h8);
    check("miss.run", 64'(dut.state_q), 64'(RUN));
    tick();
    check_head("miss.next", 32'hC);

    // Redirect with three entries queued; target low bits are cleared.
    do_reset();
    stall_in = 1'b1;
    for (int c = 1; c <= 4; c++) tick();
    check("br.count_before", 64'(fq_count), 64'd3);
    br_tk    = 1'b1;
    pc_br_tk = 32'h103;
    settle();
    check("br.valid", 64'(inst_out.valid), 64'd0);
    check("br.req",   64'(ic_if.ic_req), 64'd0);
    tick();
    br_tk    = 1'b0;
    stall_in = 1'b0;
    settle();
    check("br.count_after", 64'(fq_count), 64'd0);
    check("br.addr",        64'(ic_if.ic_addr), 64'h100);
    check("br.req_after",   64'(ic_if.ic_req), 64'd1);
    tick();
    check_head("br.target", 32'h100);

    // Redirect during MISS while decode stalls.
    do_reset();
    stall_in = 1'b1;
    tick();
    tick();
    tick();
    ic_if.ic_miss = 1'b1;
    tick();
    check("brm.state_miss", 64'(dut.state_q), 64'(MISS));
    check("brm.count",      64'(fq_count), 64'd2);
    br_tk    = 1'b1;
    pc_br_tk = 32'h200;
    settle();
    check("brm.valid", 64'(inst_out.valid), 64'd0);
    tick();
    br_tk         = 1'b0;
    ic_if.ic_miss = 1'b0;
    settle();
    check("brm.state_run", 64'(dut.state_q), 64'(RUN));
    check("brm.flushed",   64'(fq_count), 64'd0);
    check("brm.addr",      64'(ic_if.ic_addr), 64'h200);

    // Reset asserted with a full queue.
    do_reset();
    stall_in = 1'b1;
    for (int c = 1; c <= 5; c++) tick();
    check("rfull.count", 64'(fq_count), 64'd4);
    rst = 1'b1;
    settle();
    check("rfull.valid", 64'(inst_out.valid), 64'd0);
    check("rfull.inst",  64'(inst_out.inst), 64'd0);
    check("rfull.req",   64'(ic_if.ic_req), 64'd0);
    tick();
    rst = 1'b0;
    settle();
    check("rfull.count_after", 64'(fq_count), 64'd0);
    check("rfull.addr",        64'(ic_if.ic_addr), 64'h0);
    check("rfull.state",       64'(dut.state_q), 64'(BOOT));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
